// File: rtl/mem_resp_pkg.sv
// Shared types and address decode for the fixed-latency memory responder.
// Response records carry valid, error flag and read data through the delay line.
package mem_resp_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] strb_t;

  typedef struct packed {
    logic  valid;
    logic  err;
    data_t rdata;
  } resp_t;

  // The explicit addr >= base test keeps an underflowed offset from aliasing into the array.
  function automatic logic in_range(addr_t addr, addr_t base, int unsigned depth);
    addr_t off;
    off = addr - base;
    return (addr >= base) && (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < depth);
  endfunction

endpackage

// File: rtl/resp_delay_line.sv
// Latency-stage shift register of responses; only the valid bits are reset.
// The output stage zeroes rdata/err whenever no response is being presented.
module resp_delay_line
  import mem_resp_pkg::*;
#(
  parameter int unsigned Latency = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid,
  input  logic        in_err,
  input  logic [31:0] in_rdata,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [Latency-1:0] vld_p;
  logic [Latency-1:0] err_p;
  data_t              rdata_p [Latency];
  resp_t              out_p;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < Latency; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    err_p[0]   <= in_err;
    rdata_p[0] <= in_rdata;
    for (int i = 1; i < Latency; i++) begin
      err_p[i]   <= err_p[i-1];
      rdata_p[i] <= rdata_p[i-1];
    end
  end

  // Output stage
  always_comb begin
    out_p       = '0;
    out_p.valid = vld_p[Latency-1];
    if (vld_p[Latency-1]) begin
      out_p.err   = err_p[Latency-1];
      out_p.rdata = rdata_p[Latency-1];
    end
  end

  assign rvalid_o = out_p.valid;
  assign err_o    = out_p.err;
  assign rdata_o  = out_p.rdata;

endmodule

// File: rtl/mem_fixed_latency_responder.sv
// Memory responder with grant throttling, an outstanding-request cap and a
// fixed response latency; reads sample the array at the accept edge.
module mem_fixed_latency_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned Depth          = 1024,
  parameter logic [31:0] BaseAddr       = 32'h8000_0000,
  parameter int unsigned Latency        = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned StallPeriod    = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] strb_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IdxW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned StallW = (StallPeriod > 1) ? $clog2(StallPeriod) : 1;

  typedef logic [IdxW-1:0] idx_t;

  data_t             mem [Depth];
  logic [3:0]        outstanding;
  logic [StallW-1:0] stall_cnt;
  logic              stall_now;
  logic              accept;
  logic              hit;
  idx_t              idx;
  resp_t             resp_p0;

  assign stall_now = (StallPeriod != 0) && (stall_cnt == StallW'(StallPeriod - 1));
  assign gnt_o     = (outstanding < 4'(MaxOutstanding)) && !stall_now;
  assign accept    = req_i && gnt_o;
  assign hit       = in_range(addr_i, BaseAddr, Depth);
  assign idx       = idx_t'((addr_i - BaseAddr) >> 2);

  // Free-running throttle phase, independent of traffic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (StallPeriod < 2 || stall_cnt == StallW'(StallPeriod - 1)) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else begin
      case ({accept, rvalid_o})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && hit && we_i) begin
      mem[idx] <= (mem[idx] & ~strb_i) | (wdata_i & strb_i);
    end
  end

  // Accept stage: read data is captured before any later write can touch the word
  always_comb begin
    resp_p0       = '0;
    resp_p0.valid = accept;
    resp_p0.err   = !hit;
    if (hit && !we_i) begin
      resp_p0.rdata = mem[idx];
    end
  end

  resp_delay_line #(
    .Latency(Latency)
  ) u_delay (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .in_valid(resp_p0.valid),
    .in_err  (resp_p0.err),
    .in_rdata(resp_p0.rdata),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o)
  );

endmodule

// File: tb/tb_mem_fixed_latency_responder.sv
// Directed bench: a default instance for data-path vectors, one with Latency=4 /
// MaxOutstanding=2 for the grant cap, and one with StallPeriod=3 for throttling.
module tb_mem_fixed_latency_responder;

  localparam int unsigned LAT = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] strb;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_m, req_l, req_s;
  logic        we;
  logic [31:0] addr, wdata, strb;

  logic        gnt_m, rvalid_m, err_m;
  logic [31:0] rdata_m;
  logic        gnt_l, rvalid_l, err_l;
  logic [31:0] rdata_l;
  logic        gnt_s, rvalid_s, err_s;
  logic [31:0] rdata_s;

  int nvec  = 0;
  int nfail = 0;

  vec_t        vt [15];
  logic [11:0] gpat;
  logic [11:0] rpat;

  always #5 clk = ~clk;

  mem_fixed_latency_responder #(
    .Latency(LAT), .MaxOutstanding(4), .StallPeriod(0)
  ) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_m), .gnt_o(gnt_m), .addr_i(addr),
    .we_i(we), .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid_m),
    .rdata_o(rdata_m), .err_o(err_m)
  );

  mem_fixed_latency_responder #(
    .Latency(4), .MaxOutstanding(2), .StallPeriod(0)
  ) dut_l (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_l), .gnt_o(gnt_l), .addr_i(addr),
    .we_i(we), .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid_l),
    .rdata_o(rdata_l), .err_o(err_l)
  );

  mem_fixed_latency_responder #(
    .Latency(2), .MaxOutstanding(4), .StallPeriod(3)
  ) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_s), .gnt_o(gnt_s), .addr_i(addr),
    .we_i(we), .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid_s),
    .rdata_o(rdata_s), .err_o(err_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One request on the default instance; response must appear on the LAT-th negedge.
  task automatic run_vec(input vec_t v, input int id);
    @(negedge clk);
    req_m = 1'b1;
    we    = v.we;
    addr  = v.addr;
    wdata = v.wdata;
    strb  = v.strb;
    check($sformatf("vec%0d gnt", id), {31'b0, gnt_m}, 32'd1);
    @(posedge clk);
    #1 req_m = 1'b0;
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge clk);
      check($sformatf("vec%0d rvalid c%0d", id, k), {31'b0, rvalid_m}, 32'(k == int'(LAT)));
    end
    check($sformatf("vec%0d rdata", id), rdata_m, v.exp_rdata);
    check($sformatf("vec%0d err", id), {31'b0, err_m}, {31'b0, v.exp_err});
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    req_m = 1'b0; req_l = 1'b0; req_s = 1'b0;
    we = 1'b0; addr = '0; wdata = '0; strb = '0;

    vt[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h8000_0010, 32'h0,         32'h0,         1'b0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 32'h8000_0020, 32'h0000_0000, 32'h0000_FF0F, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 32'h8000_0020, 32'h0,         32'h0,         1'b0, 32'hFFFF_00F0};
    vt[5]  = '{1'b1, 32'h8000_0030, 32'h0000_0011, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 32'h8000_0FFC, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[7]  = '{1'b1, 32'h8000_0000, 32'h0123_4567, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         32'h0,         1'b1, 32'h0};
    vt[9]  = '{1'b1, 32'h7FFF_FFFC, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vt[10] = '{1'b1, 32'h8000_0002, 32'hBBBB_BBBB, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vt[11] = '{1'b1, 32'h8000_1000, 32'hCCCC_CCCC, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vt[12] = '{1'b0, 32'h8000_1000, 32'h0,         32'h0,         1'b1, 32'h0};
    vt[13] = '{1'b0, 32'h8000_0FFC, 32'h0,         32'h0,         1'b0, 32'h5A5A_5A5A};
    vt[14] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b0, 32'h0123_4567};

    #3;
    check("reset rvalid", {31'b0, rvalid_m}, 32'd0);
    check("reset rdata", rdata_m, 32'd0);
    check("reset err", {31'b0, err_m}, 32'd0);
    check("reset gnt", {31'b0, gnt_m}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_vec(vt[i], i);
    end

    // Read of 0x11 then write of 0x22 to the same word on consecutive edges.
    @(negedge clk);
    req_m = 1'b1; we = 1'b0; addr = 32'h8000_0030;
    check("rbw read gnt", {31'b0, gnt_m}, 32'd1);
    @(posedge clk);
    #1 we = 1'b1; wdata = 32'h0000_0022; strb = 32'hFFFF_FFFF;
    check("rbw write gnt", {31'b0, gnt_m}, 32'd1);
    @(posedge clk);
    #1 req_m = 1'b0; we = 1'b0;
    @(negedge clk);
    check("rbw read rvalid", {31'b0, rvalid_m}, 32'd1);
    check("rbw read rdata", rdata_m, 32'h0000_0011);
    check("rbw read err", {31'b0, err_m}, 32'd0);
    @(negedge clk);
    check("rbw write rvalid", {31'b0, rvalid_m}, 32'd1);
    check("rbw write rdata", rdata_m, 32'd0);
    @(negedge clk);
    check("rbw idle rvalid", {31'b0, rvalid_m}, 32'd0);
    v = '{1'b0, 32'h8000_0030, 32'h0, 32'h0, 1'b0, 32'h0000_0022};
    run_vec(v, 100);

    // Latency 4 with at most 2 outstanding: grant repeats 1,1,0,0,0.
    gpat = 12'b110001100011;
    rpat = 12'b000011000110;
    @(negedge clk);
    req_l = 1'b1; we = 1'b0; addr = 32'h8000_0000;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("limit gnt c%0d", k), {31'b0, gnt_l}, {31'b0, gpat[11-k]});
      check($sformatf("limit rvalid c%0d", k), {31'b0, rvalid_l}, {31'b0, rpat[11-k]});
      @(negedge clk);
    end
    req_l = 1'b0;
    repeat (8) @(negedge clk);

    // Reset with two reads in flight, then stall phase from a known counter value.
    @(negedge clk);
    req_m = 1'b1; we = 1'b0; addr = 32'h8000_0010;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 req_m = 1'b0;
    @(negedge clk);
    check("pre-reset rvalid", {31'b0, rvalid_m}, 32'd1);
    check("pre-reset rdata", rdata_m, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    check("in-reset rvalid", {31'b0, rvalid_m}, 32'd0);
    check("in-reset rdata", rdata_m, 32'd0);
    check("in-reset err", {31'b0, err_m}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      check($sformatf("stall gnt c%0d", k), {31'b0, gnt_s}, 32'((k % 3) != 2));
      check($sformatf("post-reset rvalid c%0d", k), {31'b0, rvalid_m}, 32'd0);
      @(negedge clk);
    end

    v = '{1'b0, 32'h8000_0010, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF};
    run_vec(v, 101);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
